// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left (serial or rotate), load.
// Saturating shift counter and a one-cycle load pulse.
module univ_shift_reg #(
  parameter int WIDTH  = 8,
  parameter int ROTATE = 0,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] Q,
  output logic             sout,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             load_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic in_r;
  logic in_l;
  logic [CNT_W-1:0] cnt_next;

  assign in_r = (ROTATE != 0) ? Q[0] : sin_r;
  assign in_l = (ROTATE != 0) ? Q[WIDTH-1] : sin_l;

  // Counter sticks at its maximum instead of wrapping
  assign cnt_next = (shift_cnt == CNT_MAX) ? shift_cnt
                  : shift_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      Q          <= '0;
      sout       <= 1'b0;
      shift_cnt  <= '0;
      load_pulse <= 1'b0;
    end else begin
      load_pulse <= 1'b0;
      if (en) begin
        unique case (mode)
          2'b00: begin
          end
          2'b01: begin
            Q         <= {in_r, Q[WIDTH-1:1]};
            sout      <= Q[0];
            shift_cnt <= cnt_next;
          end
          2'b10: begin
            Q         <= {Q[WIDTH-2:0], in_l};
            sout      <= Q[WIDTH-1];
            shift_cnt <= cnt_next;
          end
          2'b11: begin
            Q          <= D;
            shift_cnt  <= '0;
            load_pulse <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
